// File: rtl/output_io_pkg.sv
// output_io_pkg: CSR map, event-clear value and writer FSM states for the output_io FIFO.
// Shared by output_fifo_writer and its sub-modules.
package output_io_pkg;
    localparam logic [2:0] FILL_LEVEL  = 3'd0;
    localparam logic [2:0] I_STATUS    = 3'd1;
    localparam logic [2:0] EVENT       = 3'd2;
    localparam logic [2:0] IENABLE     = 3'd3;
    localparam logic [2:0] ALMOSTFULL  = 3'd4;
    localparam logic [2:0] ALMOSTEMPTY = 3'd5;
    localparam logic [31:0] EVENT_CLEAR_ALL = 32'h0000_003F;
    typedef enum logic [1:0] {INIT, POLL, CAPT, STREAM} state_t;
endpackage

// File: rtl/owb_word_buffer.sv
// owb_word_buffer: circular synchronous FIFO holding words for output_fifo_writer.
// Ports: clk, rst (sync, active-high), push/wdata (enqueue), pop (dequeue head),
//        head (oldest word), full, empty, count (occupancy).
module owb_word_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [DATA_W-1:0]            wdata,
    output logic [DATA_W-1:0]            head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_d  = push ? wr_q + 1'b1 : wr_q;
        rd_d  = pop ? rd_q + 1'b1 : rd_q;
        cnt_d = cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= wdata;
    end

    assign head  = mem_q[rd_q];
    assign full  = cnt_q == CW'(DEPTH);
    assign empty = cnt_q == '0;
    assign count = cnt_q;
endmodule

// File: rtl/output_fifo_writer.sv
// output_fifo_writer: Avalon-MM master feeding the output_io FIFO from a valid/ready word stream.
// Ports: clk_clk, reset_reset (sync, active-high); in_data/in_valid/in_ready core stream;
//        output_fifo_in_* FIFO data write port; output_fifo_in_csr_* CSR port;
//        busy (buffer non-empty or write pending); words_sent (accepted FIFO writes).
module output_fifo_writer #(
    parameter int DATA_W     = 32,
    parameter int BUF_DEPTH  = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [31:0]       output_fifo_in_writedata,
    output logic              output_fifo_in_write,
    input  logic              output_fifo_in_waitrequest,
    output logic [2:0]        output_fifo_in_csr_address,
    output logic              output_fifo_in_csr_read,
    output logic [31:0]       output_fifo_in_csr_writedata,
    output logic              output_fifo_in_csr_write,
    input  logic [31:0]       output_fifo_in_csr_readdata,
    output logic              busy,
    output logic [31:0]       words_sent
);
    import output_io_pkg::*;

    localparam int CW  = $clog2(FIFO_DEPTH+1);
    localparam int BCW = $clog2(BUF_DEPTH+1);

    state_t            state_q, state_d;
    logic [CW-1:0]     credit_q, credit_d;
    logic [31:0]       words_sent_q, words_sent_d;
    logic              csr_write_q, csr_write_d, csr_read_q, csr_read_d;
    logic [2:0]        csr_address_q, csr_address_d;
    logic [31:0]       csr_writedata_q, csr_writedata_d;
    logic              push, pop, full, empty, fill_ok;
    logic [BCW-1:0]    count, occ_next;
    logic [DATA_W-1:0] head;

    owb_word_buffer #(.DATA_W(DATA_W), .DEPTH(BUF_DEPTH)) u_buf (
        .clk   (clk_clk),
        .rst   (reset_reset),
        .push  (push),
        .pop   (pop),
        .wdata (in_data),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign in_ready             = !full && state_q != INIT;
    assign push                 = in_valid && in_ready;
    assign output_fifo_in_write = state_q == STREAM && !empty && credit_q != '0;
    assign pop                  = output_fifo_in_write && !output_fifo_in_waitrequest;

    always_comb begin
        occ_next     = count + BCW'(push) - BCW'(pop);
        // Any upper bit set means the fill level exceeds the FIFO depth.
        fill_ok      = output_fifo_in_csr_readdata[31:CW] == '0 &&
                       output_fifo_in_csr_readdata[CW-1:0] <= CW'(FIFO_DEPTH);
        credit_d     = pop ? credit_q - 1'b1 : credit_q;
        words_sent_d = pop ? words_sent_q + 32'd1 : words_sent_q;
        state_d      = state_q;
        case (state_q)
            // INIT spends one cycle with the event-clear write on the bus.
            INIT: state_d = csr_write_q ? POLL : INIT;
            POLL: state_d = CAPT;
            CAPT: begin
                credit_d = fill_ok ? CW'(FIFO_DEPTH) - output_fifo_in_csr_readdata[CW-1:0] : '0;
                state_d  = credit_d == '0 ? POLL : STREAM;
            end
            default: state_d = (credit_d == '0 && occ_next != '0) ? POLL : STREAM;
        endcase
        // CSR strobes are registered from the next state so they line up with it.
        csr_write_d     = state_d == INIT;
        csr_read_d      = state_d == POLL;
        csr_address_d   = state_d == INIT ? EVENT : FILL_LEVEL;
        csr_writedata_d = state_d == INIT ? EVENT_CLEAR_ALL : 32'd0;
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q         <= INIT;
            credit_q        <= '0;
            words_sent_q    <= '0;
            csr_write_q     <= 1'b0;
            csr_read_q      <= 1'b0;
            csr_address_q   <= '0;
            csr_writedata_q <= '0;
        end else begin
            state_q         <= state_d;
            credit_q        <= credit_d;
            words_sent_q    <= words_sent_d;
            csr_write_q     <= csr_write_d;
            csr_read_q      <= csr_read_d;
            csr_address_q   <= csr_address_d;
            csr_writedata_q <= csr_writedata_d;
        end
    end

    assign output_fifo_in_writedata     = 32'(head);
    assign output_fifo_in_csr_write     = csr_write_q;
    assign output_fifo_in_csr_read      = csr_read_q;
    assign output_fifo_in_csr_address   = csr_address_q;
    assign output_fifo_in_csr_writedata = csr_writedata_q;
    assign busy                         = !empty || output_fifo_in_write;
    assign words_sent                   = words_sent_q;
endmodule

// File: tb/tb_output_fifo_writer.sv
// tb_output_fifo_writer: directed, table-driven self-checking bench for output_fifo_writer.
module tb_output_fifo_writer;
    logic        clk_clk = 1'b0;
    logic        reset_reset = 1'b1;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] writedata;
    logic        write;
    logic        waitreq = 1'b0;
    logic [2:0]  csr_addr;
    logic        csr_read;
    logic [31:0] csr_wdata;
    logic        csr_write;
    logic [31:0] fill = '0;
    logic        busy;
    logic [31:0] words_sent;

    int passed = 0;
    int total  = 0;

    output_fifo_writer dut (
        .clk_clk                      (clk_clk),
        .reset_reset                  (reset_reset),
        .in_data                      (in_data),
        .in_valid                     (in_valid),
        .in_ready                     (in_ready),
        .output_fifo_in_writedata     (writedata),
        .output_fifo_in_write         (write),
        .output_fifo_in_waitrequest   (waitreq),
        .output_fifo_in_csr_address   (csr_addr),
        .output_fifo_in_csr_read      (csr_read),
        .output_fifo_in_csr_writedata (csr_wdata),
        .output_fifo_in_csr_write     (csr_write),
        .output_fifo_in_csr_readdata  (fill),
        .busy                         (busy),
        .words_sent                   (words_sent)
    );

    always #5 clk_clk = ~clk_clk;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        wr;
        logic [31:0] wd;
        logic [31:0] ws;
        logic        bz;
    } vec_t;

    vec_t vt[5];

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic do_reset();
        reset_reset = 1'b1;
        tick();
        reset_reset = 1'b0;
    endtask

    initial begin
        logic [31:0] q[$];
        logic [31:0] exp;
        int nxt, writes;
        bit first;
        vt[0] = '{1'b1, 32'hA5A5_0001, 1'b1, 32'hA5A5_0001, 32'd0, 1'b1};
        vt[1] = '{1'b1, 32'hA5A5_0002, 1'b1, 32'hA5A5_0002, 32'd1, 1'b1};
        vt[2] = '{1'b1, 32'hA5A5_0003, 1'b1, 32'hA5A5_0003, 32'd2, 1'b1};
        vt[3] = '{1'b1, 32'hA5A5_0004, 1'b1, 32'hA5A5_0004, 32'd3, 1'b1};
        vt[4] = '{1'b0, 32'h0,         1'b0, 32'hA5A5_0004, 32'd4, 1'b0};

        tick();
        tick();
        check("rst_csr_write", csr_write, 0);
        check("rst_csr_read", csr_read, 0);
        check("rst_csr_addr", csr_addr, 0);
        check("rst_csr_wdata", csr_wdata, 0);
        check("rst_write", write, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_words", words_sent, 0);
        reset_reset = 1'b0;
        tick();
        check("init_csr_write", csr_write, 1);
        check("init_csr_addr", csr_addr, 2);
        check("init_csr_wdata", csr_wdata, 32'h3F);
        check("init_csr_read", csr_read, 0);
        check("init_in_ready", in_ready, 0);
        tick();
        check("poll_csr_read", csr_read, 1);
        check("poll_csr_write", csr_write, 0);
        check("poll_csr_addr", csr_addr, 0);
        tick();
        check("capt_csr_read", csr_read, 0);
        check("c3_in_ready", in_ready, 1);
        tick();
        check("stream_write", write, 0);

        for (int i = 0; i < 5; i++) begin
            in_valid = vt[i].v;
            in_data  = vt[i].d;
            tick();
            check("tbl_write", write, vt[i].wr);
            if (vt[i].wr) check("tbl_wdata", writedata, vt[i].wd);
            check("tbl_words", words_sent, vt[i].ws);
            check("tbl_busy", busy, vt[i].bz);
            check("tbl_in_ready", in_ready, 1);
        end

        waitreq  = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("wait_write", write, 1);
            check("wait_wdata", writedata, 32'hDEAD_BEEF);
            check("wait_words", words_sent, 4);
            tick();
        end
        waitreq = 1'b0;
        check("wait_release_write", write, 1);
        tick();
        check("wait_done_words", words_sent, 5);
        check("wait_done_write", write, 0);

        fill = 32'd14;
        do_reset();
        repeat (4) tick();
        in_valid = 1'b1;
        in_data  = 32'hB000_0001;
        tick();
        check("c2_w1", writedata, 32'hB000_0001);
        in_data = 32'hB000_0002;
        tick();
        check("c2_w2", writedata, 32'hB000_0002);
        in_data = 32'hB000_0003;
        tick();
        in_valid = 1'b0;
        check("c2_poll_write", write, 0);
        check("c2_poll_read", csr_read, 1);
        check("c2_words", words_sent, 2);
        fill = 32'd16;
        tick();
        check("rp_capt1", csr_read, 0);
        check("rp_write1", write, 0);
        tick();
        check("rp_poll2", csr_read, 1);
        fill = 32'h20;
        tick();
        check("rp_capt2", csr_read, 0);
        tick();
        check("rp_upper_poll", csr_read, 1);
        check("rp_upper_write", write, 0);
        fill = 32'd10;
        tick();
        check("rp_capt3_write", write, 0);
        tick();
        check("resume_write", write, 1);
        check("resume_wdata", writedata, 32'hB000_0003);
        tick();
        check("resume_words", words_sent, 3);
        check("resume_busy", busy, 0);
        fill = 32'd16;
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_data = 32'hC000_0000 + i;
            tick();
        end
        in_valid = 1'b0;
        repeat (4) tick();
        check("credit6_words", words_sent, 8);
        check("credit6_write", write, 0);
        check("credit6_busy", busy, 1);

        fill = 32'd16;
        do_reset();
        repeat (3) tick();
        nxt = 0;
        writes = 0;
        first = 1'b1;
        in_valid = 1'b1;
        in_data = 32'hD000_0000;
        for (int c = 0; c < 40; c++) begin
            if (c == 6) fill = 32'd0;
            if (c < 4) check("fill_in_ready", in_ready, 1);
            if (c == 4) check("full_in_ready", in_ready, 0);
            if (write && first) begin
                check("full_pop_in_ready", in_ready, 0);
                first = 1'b0;
            end
            if (write && !waitreq) begin
                exp = q.size() > 0 ? q.pop_front() : 32'hFFFF_FFFF;
                check("order", writedata, exp);
                writes++;
            end
            if (in_valid && in_ready) begin
                q.push_back(in_data);
                nxt++;
            end
            tick();
            in_data = 32'hD000_0000 + nxt;
            if (nxt == 10) in_valid = 1'b0;
        end
        check("sb_writes", writes, 10);
        check("sb_words", words_sent, 10);
        check("sb_busy", busy, 0);

        waitreq  = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'hE000_0000;
        tick();
        in_valid = 1'b0;
        check("mid_write", write, 1);
        reset_reset = 1'b1;
        tick();
        check("mid_rst_write", write, 0);
        check("mid_rst_words", words_sent, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_ready", in_ready, 0);
        reset_reset = 1'b0;
        waitreq = 1'b0;
        tick();
        check("restart_csr_write", csr_write, 1);
        check("restart_csr_addr", csr_addr, 2);
        check("restart_csr_wdata", csr_wdata, 32'h3F);
        check("restart_write", write, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/output_fifo_writer.md
Name: output_fifo_writer

Overview:
- Avalon-MM master that feeds the output_io FIFO write slave (output_fifo_in) and its CSR slave from a core-side valid/ready word stream.
- Buffers words locally and issues Avalon writes that honour waitrequest.
- Tracks remote FIFO space with a credit counter, refreshed by polling the CSR fill_level register, so the core never stalls the interconnect on a full FIFO.
- Sits between the processor output path and the output_io subsystem.

Parameters:
- DATA_W, 32, word width on stream and FIFO data port.
- BUF_DEPTH, 4, local buffer entries; power of two, at least 2.
- FIFO_DEPTH, 16, depth of the remote output FIFO; upper bound for credits.

Ports:
- clk_clk  in  1  system clock.
- reset_reset  in  1  synchronous, active-high reset.
- in_data  in  DATA_W  word from core.
- in_valid  in  1  in_data valid.
- in_ready  out  1  buffer can accept; a transfer occurs when in_valid and in_ready are both high.
- output_fifo_in_writedata  out  32  FIFO write data.
- output_fifo_in_write  out  1  FIFO write request.
- output_fifo_in_waitrequest  in  1  slave stall.
- output_fifo_in_csr_address  out  3  CSR word address.
- output_fifo_in_csr_read  out  1  CSR read strobe.
- output_fifo_in_csr_writedata  out  32  CSR write data.
- output_fifo_in_csr_write  out  1  CSR write strobe.
- output_fifo_in_csr_readdata  in  32  CSR read data, valid exactly 1 cycle after csr_read.
- busy  out  1  buffer non-empty or write pending.
- words_sent  out  32  count of accepted FIFO writes; wraps at 2^32.

Behaviour:
- Clock and reset: one clock, clk_clk. reset_reset is synchronous and active-high.
- Reset values: all outputs 0, except in_ready=0 until INIT completes. Buffer empty, credit=0, state=INIT.
- Reset mid-operation: an in-flight Avalon write or CSR read is abandoned at the reset edge. Buffered words are discarded.
- Local buffer: circular, BUF_DEPTH entries.
  - in_ready = !full && state!=INIT.
  - Push and pop in the same cycle are allowed; occupancy is unchanged.
  - There is no bypass when full.
- State INIT (1 cycle): csr_write=1, csr_address=2 (event register), csr_writedata=0x3F to clear stale events. Next state: POLL.
- State POLL (1 cycle): csr_read=1, csr_address=0 (fill_level). Next state: CAPT.
- State CAPT: sample csr_readdata.
  - credit = FIFO_DEPTH - readdata when readdata <= FIFO_DEPTH; otherwise credit = 0.
  - If credit==0, next state is POLL; re-polling is continuous.
  - Otherwise, next state is STREAM.
- State STREAM:
  - When the buffer is non-empty and credit>0, assert write with writedata = buffer head.
  - While waitrequest=1, write and writedata are held stable.
  - On a cycle with write=1 and waitrequest=0: pop the head, decrement credit, increment words_sent. Back-to-back writes are allowed the following cycle.
  - When credit reaches 0 and the buffer is non-empty, next state is POLL.
  - An idle buffer stays in STREAM.
- Credit accounting:
  - credit width is clog2(FIFO_DEPTH+1).
  - credit is never incremented except by a poll, so it never exceeds FIFO_DEPTH.
- Width of csr_readdata: only bits [clog2(FIFO_DEPTH+1)-1:0] are compared after an all-upper-bits-zero check. Any upper bit set is treated as > FIFO_DEPTH.
- Latency: a word pushed into an empty buffer in STREAM with credit>0 appears on write in the next cycle.
- CSR mutual exclusion: csr_read and csr_write are never high together. No CSR access occurs while write=1.
- busy = buffer non-empty || write.

Decomposition:
- Package output_io_pkg holds:
  - CSR address constants: FILL_LEVEL=0, I_STATUS=1, EVENT=2, IENABLE=3, ALMOSTFULL=4, ALMOSTEMPTY=5.
  - EVENT_CLEAR_ALL=0x3F.
  - State enum {INIT, POLL, CAPT, STREAM}.
- One sub-module, owb_word_buffer: a parameterised synchronous FIFO with push/pop/full/empty and head data.

Test Plan:
- Reset, then idle → cycle 1: csr_write=1, addr=2, data=0x3F. Cycle 2: csr_read=1, addr=0. Readdata 0 → STREAM with credit 16, and in_ready=1 from cycle 3.
- Push 0xA5A5_0001..0004 with waitrequest=0 → four consecutive writes in order, words_sent=4, busy drops the cycle after the last acceptance.
- Hold waitrequest=1 for 5 cycles on word 0xDEAD_BEEF → write and writedata stable all 5 cycles. Single acceptance; words_sent increments by 1.
- Fill_level reads 14 → after 2 writes the block enters POLL. Readdata 16 forces repeated polls with no writes. Readdata 10 then resumes with credit 6.
- Keep in_valid high with the remote stalled → in_ready deasserts after 4 pushes. Simultaneous push and pop at full keeps in_ready=0 and preserves order.
- Assert reset_reset mid-write (waitrequest=1) → next cycle write=0, words_sent=0, buffer empty, and the INIT sequence restarts.
